// File: rtl/lfsr_decrypt_ctrl.sv
// lfsr_decrypt_ctrl: recovers the LFSR seed and tap pattern of the
// encrypted message in data memory, decrypts it into addresses 0..MSG_LEN-1,
// and optionally strips the leading spaces.
//
// Optional feature macro: DECRYPT_SPACE_STRIP_EN
//   defined   -> leading-space counting and the COMPACT pass are built in.
//   undefined -> DECRYPT goes straight to DONE and space_ct is tied to 0.
//
// Ports:
//   clk, init_n           clock, asynchronous active-low reset
//   start                 begin a run (sampled only in IDLE)
//   busy, done            running / one-cycle completion pulse
//   err                   no tap pattern matched the preamble
//   tap_sel, space_ct     matched tap index, leading spaces removed
//   mem_addr/we/wdata     single-port memory request
//   mem_rdata             read data, valid one cycle after a read address

// One candidate tap pattern. It replays the LFSR from s_0 and drops out
// as soon as its prediction disagrees with a recovered preamble state.
module lfsr_trial (
  input  logic       clk,
  input  logic       init_n,
  input  logic       clr,
  input  logic       load,
  input  logic       step,
  input  logic [7:0] tap,
  input  logic [7:0] s,
  output logic       alive
);
  logic [7:0] trial, nxt;

  assign nxt = {trial[6:0], ^(trial & tap)};

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      trial <= '0;
      alive <= 1'b1;
    end else if (clr) begin
      alive <= 1'b1;
    end else if (load) begin
      trial <= s;
    end else if (step) begin
      trial <= nxt;
      if (nxt != s) alive <= 1'b0;
    end
  end
endmodule

module lfsr_decrypt_ctrl #(
  parameter logic [7:0] MSG_BASE  = 8'd64,
  parameter logic [7:0] MSG_LEN   = 8'd64,
  parameter logic [7:0] PAD       = 8'hA0
`ifdef DECRYPT_SPACE_STRIP_EN
  , parameter logic [4:0] MAX_SPACE = 5'd25
`endif
) (
  input  logic       clk,
  input  logic       init_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] tap_sel,
  output logic [4:0] space_ct,
  output logic [7:0] mem_addr,
  output logic       mem_we,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata
);
  typedef enum logic [2:0] {
    S_IDLE, S_SEED, S_PICK, S_DEC, S_DONE
`ifdef DECRYPT_SPACE_STRIP_EN
    , S_CMP
`endif
  } state_t;

  // Tap ROM, index 0 is the rightmost entry.
  localparam logic [7:0][7:0] TAPS =
    {8'hF3, 8'hFA, 8'hB2, 8'hB4, 8'hB8, 8'hC6, 8'hD4, 8'hE1};

  function automatic logic [7:0] lfsr_step(input logic [7:0] s, input logic [7:0] t);
    return {s[6:0], ^(s & t)};
  endfunction

  state_t     state_q, state_d;
  logic       phase;          // 0 = address cycle, 1 = data/write cycle
  logic [7:0] idx;
  logic [7:0] s0, lfsr;
  logic [7:0] mask;
  logic [2:0] pick;
  logic [7:0] seed_val, plain;
  logic       seed_last, msg_last;

  assign seed_val  = mem_rdata ^ PAD;
  assign plain     = mem_rdata ^ lfsr;
  assign seed_last = (idx == 8'd8);
  assign msg_last  = (idx == MSG_LEN - 8'd1);
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done      = (state_q == S_DONE);

  for (genvar k = 0; k < 8; k++) begin : g_lane
    lfsr_trial u_lane (
      .clk   (clk),
      .init_n(init_n),
      .clr   (state_q == S_IDLE),
      .load  (state_q == S_SEED && phase && idx == 8'd0),
      .step  (state_q == S_SEED && phase && idx != 8'd0),
      .tap   (TAPS[k]),
      .s     (seed_val),
      .alive (mask[k])
    );
  end

  // Later matches overwrite earlier ones, so the highest surviving index wins.
  always_comb begin
    pick = 3'd0;
    for (int k = 0; k < 8; k++)
      if (mask[k]) pick = 3'(k);
  end

`ifdef DECRYPT_SPACE_STRIP_EN
  logic [4:0] space_ct_q, sc_nxt;
  logic       sp_run, space_hit;
  logic [7:0] cmp_src;
  logic       cmp_in;

  // sp_run stays set only while every decrypted byte so far was a space.
  assign space_hit = sp_run && (plain[6:0] == 7'h20);
  assign sc_nxt    = space_ct_q + 5'(space_hit && (space_ct_q < MAX_SPACE));
  assign cmp_src   = idx + {3'b000, space_ct_q};
  assign cmp_in    = (cmp_src < MSG_LEN);
  assign space_ct  = space_ct_q;

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      space_ct_q <= '0;
      sp_run     <= 1'b0;
    end else if (state_q == S_IDLE && start) begin
      space_ct_q <= '0;
      sp_run     <= 1'b1;
    end else if (state_q == S_DEC && phase) begin
      space_ct_q <= sc_nxt;
      if (!space_hit) sp_run <= 1'b0;
    end
  end
`else
  assign space_ct = '0;
`endif

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (state_q)
      S_IDLE: if (start) state_d = S_SEED;
      S_SEED: begin
        mem_addr = MSG_BASE + idx;
        if (phase && seed_last) state_d = S_PICK;
      end
      S_PICK: state_d = (|mask) ? S_DEC : S_DONE;
      S_DEC: begin
        if (!phase) begin
          mem_addr = MSG_BASE + idx;
        end else begin
          mem_addr  = idx;
          mem_we    = 1'b1;
          mem_wdata = plain;
`ifdef DECRYPT_SPACE_STRIP_EN
          if (msg_last) state_d = (sc_nxt == 5'd0) ? S_DONE : S_CMP;
`else
          if (msg_last) state_d = S_DONE;
`endif
        end
      end
`ifdef DECRYPT_SPACE_STRIP_EN
      S_CMP: begin
        // Past the end of the shifted message the address cycle is idle.
        if (!phase) begin
          mem_addr = cmp_in ? cmp_src : idx;
        end else begin
          mem_addr  = idx;
          mem_we    = 1'b1;
          mem_wdata = cmp_in ? mem_rdata : 8'h20;
          if (msg_last) state_d = S_DONE;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      phase   <= 1'b0;
      idx     <= '0;
      s0      <= '0;
      lfsr    <= '0;
      tap_sel <= '0;
      err     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          phase <= 1'b0;
          idx   <= '0;
          if (start) begin
            err     <= 1'b0;
            tap_sel <= '0;
          end
        end
        S_SEED: begin
          phase <= ~phase;
          if (phase) begin
            idx <= seed_last ? 8'd0 : idx + 8'd1;
            if (idx == 8'd0) s0 <= seed_val;
          end
        end
        S_PICK: begin
          phase <= 1'b0;
          idx   <= '0;
          if (|mask) begin
            tap_sel <= pick;
            lfsr    <= s0;
          end else begin
            err <= 1'b1;
          end
        end
        S_DEC: begin
          phase <= ~phase;
          if (phase) begin
            lfsr <= lfsr_step(lfsr, TAPS[tap_sel]);
            idx  <= msg_last ? 8'd0 : idx + 8'd1;
          end
        end
`ifdef DECRYPT_SPACE_STRIP_EN
        S_CMP: begin
          phase <= ~phase;
          if (phase) idx <= msg_last ? 8'd0 : idx + 8'd1;
        end
`endif
        default: ;
      endcase
    end
  end
endmodule
